// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types for the iterative divide unit
package pipeline;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    div_op_t op;
    logic    word;
    word_t   a;
    word_t   b;
  } div_req_t;

  function automatic logic is_signed_op(input div_op_t o);
    return (o == DIV) || (o == REM);
  endfunction

  function automatic logic is_rem_op(input div_op_t o);
    return (o == REM) || (o == REMU);
  endfunction

endpackage

// File: rtl/divider_iter.sv
// rtl/divider_iter.sv - one combinational radix-2 restoring divide step
module div_iter #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic           ge;

  // Shift the next dividend bit in, trial-subtract, and shift the quotient bit in.
  // The extra top bit keeps the trial compare exact when the divisor uses bit WIDTH-1.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, div_i});
    rem_o  = ge ? (rem_sh[WIDTH-1:0] - div_i) : rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative RV64 divide/remainder unit with valid/ready handshake
module divider
  import pipeline::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  div_op_t          op,
  input  logic             word,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_W = {{(WIDTH-31){1'b1}}, {31{1'b0}}};

  // W results are always bit-31 sign-extended, unsigned variants included.
  function automatic logic [WIDTH-1:0] wfix(input logic [WIDTH-1:0] x, input logic w);
    return w ? {{(WIDTH-32){x[31]}}, x[31:0]} : x;
  endfunction

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  div_op_t          op_q, op_d;
  logic             word_q, word_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  div_req_t         req;
  logic             sgn;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, dvd_init, special_res;
  logic             a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin, res_fin;

  assign req = '{op: op, word: word, a: a, b: b};

  // Operand preparation: width selection, magnitudes, sign flags and special cases.
  always_comb begin
    sgn      = is_signed_op(req.op);
    a_ext    = req.word ? {{(WIDTH-32){req.a[31] & sgn}}, req.a[31:0]} : req.a;
    b_ext    = req.word ? {{(WIDTH-32){req.b[31] & sgn}}, req.b[31:0]} : req.b;
    a_neg    = sgn & a_ext[WIDTH-1];
    b_neg    = sgn & b_ext[WIDTH-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    // W dividends start in the top half so 32 shifts consume exactly their bits.
    dvd_init = req.word ? {a_mag[31:0], {(WIDTH-32){1'b0}}} : a_mag;
    div_zero = (b_ext == '0);
    ovf      = sgn && (a_ext == (req.word ? MIN_W : MIN_D)) && (b_ext == '1);
    if (is_rem_op(req.op)) special_res = div_zero ? a_ext : '0;
    else                   special_res = div_zero ? '1 : a_ext;
    special_res = wfix(special_res, req.word);
  end

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(rem_nx),
    .quo_o(quo_nx)
  );

  // Post-fix applied to the final step's outputs as the unit enters DONE.
  always_comb begin
    q_fin   = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fin   = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    res_fin = wfix(is_rem_op(op_q) ? r_fin : q_fin, word_q);
  end

  // Control FSM next-state: accept, iterate, hold result; flush wins over everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d   = req.op;
          word_d = req.word;
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = dvd_init;
            div_d     = b_mag;
            cnt_d     = req.word ? CNT_W'(32) : CNT_W'(WIDTH);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = res_fin;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      op_q      <= DIV;
      word_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && reset;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed table-driven bench for the divide unit
module tb_divider;
  import pipeline::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  div_op_t     op_r = DIV;
  logic        word_r = 1'b0;
  logic [63:0] a_r = '0;
  logic [63:0] b_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_chk = 0;
  int n_pass = 0;

  divider #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op_r), .word(word_r), .a(a_r), .b(b_r),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    div_op_t     op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic start_op(input div_op_t o, input logic w, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    op_r = o; word_r = w; a_r = x; b_r = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    vecs[0]  = '{DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{REM,  1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[6]  = '{DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[7]  = '{DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[8]  = '{REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{DIVU, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[10] = '{REMU, 1'b1, 64'd7, 64'hABCD_0000_0000_0000, 64'd7, 1};
    vecs[11] = '{REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[12] = '{DIV,  1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 33};
    vecs[13] = '{DIVU, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 64'h0000_0000_5555_5550, 33};
    vecs[14] = '{REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};
    vecs[15] = '{REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    reset = 1'b1;

    // Table of directed vectors
    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b);
      wait_valid(cyc);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      chk($sformatf("vec%0d_cycle", i), 64'(cyc), 64'(vecs[i].cyc));
      consume();
    end

    // Flush in cycle 10 of BUSY; a request in the flush cycle must be dropped
    start_op(DIVU, 1'b0, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op_r = DIVU; a_r = 64'd9; b_r = 64'd3;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("flush_no_valid_stays_idle", {63'd0, seen}, 64'd0);
    start_op(DIVU, 1'b0, 64'd9, 64'd3);
    wait_valid(cyc);
    chk("after_flush_result", result, 64'd3);
    chk("after_flush_cycle", 64'(cyc), 64'd65);

    // Backpressure: result held, in_ready low for 5 cycles of stall
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_result", k), result, 64'd3);
      chk($sformatf("bp%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
    end
    consume();
    @(negedge clk);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

    // out_ready during BUSY is ignored
    start_op(DIVU, 1'b0, 64'd1000, 64'd10);
    out_ready = 1'b1;
    wait_valid(cyc);
    chk("ready_busy_result", result, 64'd100);
    chk("ready_busy_cycle", 64'(cyc), 64'd65);
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset asserted mid-BUSY
    start_op(DIV, 1'b0, 64'd77, 64'd7);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_idle", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midreset_no_residual_valid", {63'd0, seen}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
